// File: rtl/serializer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serializer_ctrl: frame scheduler for the IQ byte serializer (rev 1.0)    |
// +--------------------------------------------------------------------------+
module serializer_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic             frame_ready,
  input  logic [7:0]       decim,
  input  logic             drop_clr,
  output logic             capture,
  output logic             start,
  output logic             byte_valid,
  output logic             byte_first,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAPT  = 3'd1,
    S_START = 3'd2,
    S_ALIGN = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [1:0] idx, idx_nx;
  logic [7:0] skip_cnt, skip_nx;
  logic       eligible, accept, drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      skip_cnt   <= 8'd0;
      capture    <= 1'b0;
      start      <= 1'b0;
      byte_valid <= 1'b0;
      byte_first <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      skip_cnt   <= skip_nx;
      // Outputs are registered from the next-state decode so they line up with the state.
      capture    <= (state_nx == S_CAPT);
      start      <= (state_nx == S_START);
      byte_valid <= (state_nx == S_SEND);
      byte_first <= (state_nx == S_SEND) && (idx_nx == 2'd0);
      busy       <= (state_nx != S_IDLE);
      if (accept) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (drop_clr) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    skip_nx  = skip_cnt;
    accept   = 1'b0;
    drop     = 1'b0;
    eligible = (state == S_IDLE) || ((state == S_SEND) && (idx == 2'd3));

    if (enable && sample_valid) begin
      if (!eligible) begin
        drop = 1'b1;
      end else if (skip_cnt != 8'd0) begin
        skip_nx = skip_cnt - 8'd1;
      end else if (frame_ready) begin
        accept  = 1'b1;
        skip_nx = decim;
      end else begin
        drop = 1'b1;
      end
    end
    if (!enable) begin
      skip_nx = 8'd0;
    end

    case (state)
      S_IDLE:  if (accept) state_nx = S_CAPT;
      S_CAPT:  state_nx = S_START;
      S_START: state_nx = S_ALIGN;
      S_ALIGN: begin
        state_nx = S_SEND;
        idx_nx   = 2'd0;
      end
      S_SEND: begin
        if (idx == 2'd3) begin
          state_nx = accept ? S_CAPT : S_IDLE;
          idx_nx   = 2'd0;
        end else begin
          idx_nx = idx + 2'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer_ctrl.sv
`default_nettype none
// Randomized scoreboard bench for serializer_ctrl: a frame-window reference model
// predicts accepts/drops; a negedge monitor pops expectations and checks outputs.
module tb_serializer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic       frame_ready = 1'b0;
  logic [7:0] decim = 8'd0;
  logic       drop_clr = 1'b0;
  logic       capture, start, byte_valid, byte_first, busy;
  logic [3:0] frame_cnt, drop_cnt;

  serializer_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .frame_ready(frame_ready), .decim(decim), .drop_clr(drop_clr),
    .capture(capture), .start(start), .byte_valid(byte_valid),
    .byte_first(byte_first), .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       rst;
    logic [3:0] fcnt;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         ed = 0;
  int         free_at = 0;
  int         m_skip = 0;
  logic [3:0] m_fcnt = 4'd0;
  logic [3:0] m_dcnt = 4'd0;
  int         last_cap = -100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ed, act, exp);
    end
  endtask

  // A frame accepted at edge e occupies the link until edge e+7, where the next may start.
  task automatic model_step();
    bit drop;
    drop = 1'b0;
    ed++;
    if (!rst_n) begin
      free_at = 0;
      m_skip  = 0;
      m_fcnt  = 4'd0;
      m_dcnt  = 4'd0;
      q.push_back('{ed, 1'b1, 4'd0});
      return;
    end
    if (enable && sample_valid) begin
      if (ed < free_at) begin
        drop = 1'b1;
      end else if (m_skip != 0) begin
        m_skip--;
      end else if (frame_ready) begin
        m_skip  = int'(decim);
        m_fcnt  = m_fcnt + 4'd1;
        free_at = ed + 7;
        q.push_back('{ed, 1'b0, m_fcnt});
      end else begin
        drop = 1'b1;
      end
    end
    if (!enable) m_skip = 0;
    if (drop_clr) m_dcnt = 4'd0;
    else if (drop && m_dcnt != 4'hF) m_dcnt = m_dcnt + 4'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    drop_clr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic samples(input int n, input int period);
    repeat (n) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      repeat (period - 1) tick();
    end
  endtask

  // Monitor: pops one expectation per observed capture, then checks the pulse train from it.
  always @(negedge clk) begin
    exp_t rec;
    int   off;
    bit   e_cap, e_st, e_bv, e_bf, e_busy;
    if (q.size() > 0 && q[0].rst && q[0].cyc == ed) begin
      void'(q.pop_front());
      last_cap = -100;
      chk("reset_pulses", {capture, start, byte_valid, byte_first, busy}, 0);
      chk("reset_frame_cnt", frame_cnt, 0);
      chk("reset_drop_cnt", drop_cnt, 0);
    end else begin
      if (capture) begin
        if (q.size() == 0 || q[0].rst) begin
          chk("capture_unexpected", 1, 0);
        end else begin
          rec = q.pop_front();
          chk("capture_edge", ed, rec.cyc);
          chk("frame_cnt", frame_cnt, rec.fcnt);
          last_cap = ed;
        end
      end else if (q.size() > 0 && !q[0].rst && q[0].cyc <= ed) begin
        chk("capture_missing", 0, q[0].cyc);
        void'(q.pop_front());
      end
      off    = ed - last_cap;
      e_cap  = (off == 0);
      e_st   = (off == 1);
      e_bv   = (off >= 3 && off <= 6);
      e_bf   = (off == 3);
      e_busy = (off >= 0 && off <= 6);
      chk("pulses", {capture, start, byte_valid, byte_first, busy},
          {e_cap, e_st, e_bv, e_bf, e_busy});
      chk("drop_cnt", drop_cnt, m_dcnt);
    end
  end

  initial begin
    logic [3:0] fc0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // single sample
    enable = 1'b1; decim = 8'd0; frame_ready = 1'b1;
    samples(1, 12);
    chk("single_frame_cnt", frame_cnt, 1);

    // back-to-back at the minimum period, then one cycle too fast
    samples(10, 7);
    idle(8);
    chk("b2b7_drops", drop_cnt, 0);
    fc0 = frame_cnt;
    samples(10, 6);
    idle(8);
    chk("b2b6_drops", drop_cnt, 5);
    chk("b2b6_frames", 4'(frame_cnt - fc0), 5);

    // decimation by 4
    decim = 8'd3;
    fc0 = frame_cnt;
    samples(12, 10);
    chk("decim_frames", 4'(frame_cnt - fc0), 3);
    chk("decim_drops", drop_cnt, 5);

    // backpressure then clear-wins-over-drop
    decim = 8'd0;
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    frame_ready = 1'b0;
    samples(2, 3);
    chk("bp_drops", drop_cnt, 2);
    frame_ready = 1'b1;
    fc0 = frame_cnt;
    samples(1, 2);
    chk("bp_sent", 4'(frame_cnt - fc0), 1);
    sample_valid = 1'b1; drop_clr = 1'b1; tick();
    sample_valid = 1'b0; drop_clr = 1'b0;
    chk("clr_wins", drop_cnt, 0);
    idle(8);

    // saturation
    frame_ready = 1'b0;
    samples(20, 2);
    chk("drop_sat", drop_cnt, 15);
    frame_ready = 1'b1;

    // reset at T4 of a frame
    samples(1, 4);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    idle(3);

    // enable dropped during SEND: frame completes, later samples ignored
    samples(1, 5);
    enable = 1'b0;
    samples(5, 2);
    chk("disabled_drops", drop_cnt, 0);
    enable = 1'b1;
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      frame_ready  = ($urandom_range(0, 4) != 0);
      decim        = 8'($urandom_range(0, 3));
      drop_clr     = ($urandom_range(0, 19) == 0);
      rst_n        = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle(10);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
